mem_arbiter: RTL and testbench

- Arbiter and sequencer for the single-ported unified instruction/data memory of the 16-bit pipelined core.
- Requesters: the fetch stage (instruction reads) and the memory stage (LW/SW, driven by decoder memRd/memWr).
- Grants one requester at a time, drives the memory for a fixed access latency, and returns data with a 1-cycle ack pulse.
- Produces stall signals so the pipeline holds while its request is outstanding.

---
 rtl/mem_arbiter.sv | 219 +++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Arbiter and sequencer for the single-ported unified instruction/data
//   memory of the 16-bit pipelined core. One requester at a time is granted;
//   the memory is driven for LATENCY cycles, then the owner gets a one-cycle
//   ack with its read data. Data requests win over fetch.
//
//   Optional build macro STARVE_GUARD_EN: after MAX_BURST consecutive data
//   grants made while a fetch was waiting, the next arbitration goes to fetch.
//   Without it, data priority is strict and fetch may starve.
//
// Parameters
//   LATENCY    memory access cycles, 1..15
//   MAX_BURST  data grants tolerated while fetch waits (STARVE_GUARD_EN only)
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   hlt                      blocks new fetch grants
//   if_req/if_addr           fetch request, held until if_ack
//   if_rdata/if_ack          fetched word and completion pulse
//   d_rd/d_wr/d_addr/d_wdata data request, held until d_ack
//   d_rdata/d_ack            load data and completion pulse
//   mem_re/mem_we/mem_addr/mem_wdata/mem_rdata  memory port
//   stall_if/stall_mem       pipeline holds while a request is outstanding
//   err                      sticky: d_rd and d_wr both high at a grant
module mem_arbiter #(
  parameter int LATENCY   = 2,
  parameter int MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hlt,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic [15:0] if_rdata,
  output logic        if_ack,
  input  logic        d_rd,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic [15:0] d_rdata,
  output logic        d_ack,
  output logic        mem_re,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        stall_if,
  output logic        stall_mem,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  localparam int                 BURST_W   = $clog2(MAX_BURST + 1);
  localparam logic [3:0]         CNT_LAST  = 4'(LATENCY - 1);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);

  state_e             state_q, state_d;
  logic               owner_q, owner_d;   // 1 = data port owns the access
  logic               we_q, we_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic [15:0]        if_rdata_q, if_rdata_d;
  logic [15:0]        d_rdata_q, d_rdata_d;
  logic               if_ack_q, if_ack_d;
  logic               d_ack_q, d_ack_d;
  logic               mem_re_q, mem_re_d;
  logic               mem_we_q, mem_we_d;
  logic [15:0]        mem_addr_q, mem_addr_d;
  logic [15:0]        mem_wdata_q, mem_wdata_d;
  logic               err_q, err_d;

  logic data_pend;
  logic if_ok;
  logic force_if;
  logic grant_data;
  logic grant_if;
  logic last_cycle;

  // Arbitration. Only the IDLE state grants; RESP deliberately ignores
  // requests because the owner is still deasserting its request.
  always_comb begin
    data_pend = d_rd | d_wr;
    if_ok     = if_req & ~hlt;
`ifdef STARVE_GUARD_EN
    force_if  = if_ok && (burst_q == BURST_MAX);
`else
    force_if  = 1'b0;
`endif
    grant_data = (state_q == IDLE) && data_pend && !force_if;
    grant_if   = (state_q == IDLE) && if_ok && (!data_pend || force_if);
    last_cycle = (state_q == BUSY) && (cnt_q == CNT_LAST);
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_data || grant_if) state_d = BUSY;
      BUSY:    if (last_cycle) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and datapath logic. Memory enables are registered so they are
  // high exactly during the LATENCY BUSY cycles. Read data is loaded into the
  // owner's register on the same edge that raises its ack, so the data is
  // valid for the whole ack cycle.
  always_comb begin
    owner_d     = owner_q;
    we_d        = we_q;
    cnt_d       = cnt_q;
    burst_d     = burst_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    mem_re_d    = mem_re_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    err_d       = err_q;

    if (grant_data) begin
      // A simultaneous read+write is executed as a write and flagged.
      owner_d     = 1'b1;
      we_d        = d_wr;
      mem_re_d    = ~d_wr;
      mem_we_d    = d_wr;
      mem_addr_d  = d_addr;
      mem_wdata_d = d_wdata;
      cnt_d       = '0;
      if (d_rd && d_wr) err_d = 1'b1;
      // The burst count tracks data grants taken while fetch was eligible;
      // it saturates so it cannot wrap when no guard acts on it.
      if (if_ok) begin
        if (burst_q != BURST_MAX) burst_d = burst_q + BURST_W'(1);
      end else if (!if_req) begin
        burst_d = '0;
      end
    end else if (grant_if) begin
      owner_d     = 1'b0;
      we_d        = 1'b0;
      mem_re_d    = 1'b1;
      mem_we_d    = 1'b0;
      mem_addr_d  = if_addr;
      mem_wdata_d = '0;
      cnt_d       = '0;
      burst_d     = '0;
    end

    if (state_q == BUSY) begin
      if (last_cycle) begin
        mem_re_d = 1'b0;
        mem_we_d = 1'b0;
        cnt_d    = '0;
        if (owner_q) d_ack_d  = 1'b1;
        else         if_ack_d = 1'b1;
        if (!we_q) begin
          if (owner_q) d_rdata_d  = mem_rdata;
          else         if_rdata_d = mem_rdata;
        end
      end else begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  // State register. Reset abandons any access in flight without an ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      we_q        <= 1'b0;
      cnt_q       <= '0;
      burst_q     <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      we_q        <= we_d;
      cnt_q       <= cnt_d;
      burst_q     <= burst_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      err_q       <= err_d;
    end
  end

  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_ack    = if_ack_q;
  assign d_ack     = d_ack_q;
  assign mem_re    = mem_re_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign err       = err_q;

  // Stalls follow the live requests so the pipeline releases in the ack cycle.
  assign stall_if  = if_req & ~if_ack_q;
  assign stall_mem = (d_rd | d_wr) & ~d_ack_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: directed timing scenarios plus randomized
// fetch/data traffic. Expected responses are queued when a request is issued
// and popped by a monitor whenever the DUT raises an ack.
module tb_mem_arbiter;

  localparam int LATENCY   = 2;
  localparam int MAX_BURST = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hlt = 1'b0;
  logic        if_req = 1'b0;
  logic [15:0] if_addr = '0;
  logic        d_rd = 1'b0;
  logic        d_wr = 1'b0;
  logic [15:0] d_addr = '0;
  logic [15:0] d_wdata = '0;
  logic [15:0] mem_rdata;
  logic [15:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic        if_ack, d_ack, mem_re, mem_we, stall_if, stall_mem, err;

  always #5 clk = ~clk;

  mem_arbiter #(.LATENCY(LATENCY), .MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .rst(rst), .hlt(hlt),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_rd(d_rd), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem), .err(err)
  );

  int checksTotal  = 0;
  int checksPassed = 0;

  typedef struct {
    logic        isWrite;
    logic [15:0] rdata;
  } dExp_t;

  logic [15:0] ifExpQ[$];
  dExp_t       dExpQ[$];
  logic        ackLog[$];      // 0 = fetch ack, 1 = data ack, in order seen
  logic [15:0] refMem [0:511];
  logic [15:0] lastLoad = '0;
  int          lat, dLat, fLat, pos, reCnt, ackCnt;

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    checksTotal++;
    if (actual === expected) checksPassed++;
    else $display("[TB] FAIL %s: got 0x%04h, want 0x%04h", name, actual, expected);
  endtask

  // Memory contents as the system sees them before any store.
  function automatic logic [15:0] initWord(input int a);
    if (a == 16) return 16'hB123;
    return 16'(a * 40503 + 4951);
  endfunction

  // Memory device: answers a read only in the LATENCY-th enabled cycle and
  // commits a write in the LATENCY-th enabled cycle.
  logic [15:0] physMem [0:511];
  logic        memLoaded = 1'b0;
  logic [3:0]  runCnt = 4'd0;

  always @(posedge clk) begin
    if (!memLoaded) begin
      for (int i = 0; i < 512; i++) physMem[i] <= initWord(i);
      memLoaded <= 1'b1;
    end else if (mem_we && runCnt == 4'(LATENCY - 1)) begin
      physMem[mem_addr[8:0]] <= mem_wdata;
    end
    runCnt <= (mem_re | mem_we) ? runCnt + 4'd1 : 4'd0;
  end

  assign mem_rdata = (mem_re && runCnt == 4'(LATENCY - 1)) ? physMem[mem_addr[8:0]] : 16'hDEAD;

  // Scoreboard monitor: every ack must match the oldest queued expectation.
  logic [15:0] monIf;
  dExp_t       monD;

  always @(negedge clk) begin
    if (if_ack === 1'b1) begin
      ackLog.push_back(1'b0);
      if (ifExpQ.size() == 0) checkOutput("spurious if_ack", 16'(if_ack), 16'd0);
      else begin
        monIf = ifExpQ.pop_front();
        checkOutput("if_rdata at if_ack", if_rdata, monIf);
      end
    end
    if (d_ack === 1'b1) begin
      ackLog.push_back(1'b1);
      if (dExpQ.size() == 0) checkOutput("spurious d_ack", 16'(d_ack), 16'd0);
      else begin
        monD = dExpQ.pop_front();
        checkOutput(monD.isWrite ? "d_rdata kept on store" : "d_rdata at load ack",
                    d_rdata, monD.rdata);
      end
    end
  end

  task automatic doReset();
    @(posedge clk); #1;
    rst = 1'b1; if_req = 1'b0; d_rd = 1'b0; d_wr = 1'b0; hlt = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    ifExpQ.delete(); dExpQ.delete(); ackLog.delete();
    lastLoad = '0;
  endtask

  // Presents a data request and records what the ack must show.
  task automatic issueData(input logic rd, input logic wr,
                           input logic [15:0] addr, input logic [15:0] wdata);
    dExp_t e;
    d_rd = rd; d_wr = wr; d_addr = addr; d_wdata = wdata;
    if (wr) begin
      refMem[addr[8:0]] = wdata;
      e.isWrite = 1'b1;
      e.rdata   = lastLoad;
    end else begin
      e.isWrite = 1'b0;
      e.rdata   = refMem[addr[8:0]];
      lastLoad  = e.rdata;
    end
    dExpQ.push_back(e);
  endtask

  // Waits for d_ack; lat is the ack cycle counted from the issue cycle (0).
  task automatic waitDataAck(input bit keep, output int l);
    for (l = 0; l < 200; l++) begin
      @(negedge clk);
      if (d_ack === 1'b1) break;
    end
    if (l == 200) checkOutput("d_ack timeout", 16'(d_ack), 16'd1);
    @(posedge clk); #1;
    if (!keep) begin d_rd = 1'b0; d_wr = 1'b0; end
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic [15:0] addr,
                               input logic [15:0] wdata, input bit keep, output int l);
    issueData(rd, wr, addr, wdata);
    waitDataAck(keep, l);
  endtask

  task automatic waitFetchAck(output int l);
    for (l = 0; l < 200; l++) begin
      @(negedge clk);
      if (if_ack === 1'b1) break;
    end
    if (l == 200) checkOutput("if_ack timeout", 16'(if_ack), 16'd1);
    @(posedge clk); #1;
    if_req = 1'b0;
  endtask

  task automatic fetchRequest(input logic [15:0] addr, output int l);
    if_req = 1'b1; if_addr = addr;
    ifExpQ.push_back(refMem[addr[8:0]]);
    waitFetchAck(l);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 512; i++) refMem[i] = initWord(i);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset if_ack", 16'(if_ack), 16'd0);
    checkOutput("reset d_ack", 16'(d_ack), 16'd0);
    checkOutput("reset mem_re", 16'(mem_re), 16'd0);
    checkOutput("reset mem_we", 16'(mem_we), 16'd0);
    checkOutput("reset mem_addr", mem_addr, 16'h0000);
    checkOutput("reset mem_wdata", mem_wdata, 16'h0000);
    checkOutput("reset if_rdata", if_rdata, 16'h0000);
    checkOutput("reset d_rdata", d_rdata, 16'h0000);
    checkOutput("reset err", 16'(err), 16'd0);
    rst = 1'b0;
    #1;
    checkOutput("idle stall_if", 16'(stall_if), 16'd0);
    checkOutput("idle stall_mem", 16'(stall_mem), 16'd0);

    // Fetch only: enables in cycles 1..LATENCY, ack in LATENCY+1
    doReset();
    if_req = 1'b1; if_addr = 16'h0010; ifExpQ.push_back(refMem[16]);
    @(negedge clk);
    checkOutput("fetch c0 stall_if", 16'(stall_if), 16'd1);
    checkOutput("fetch c0 mem_re", 16'(mem_re), 16'd0);
    for (int c = 1; c <= LATENCY; c++) begin
      @(negedge clk);
      checkOutput("fetch mem_re", 16'(mem_re), 16'd1);
      checkOutput("fetch mem_addr", mem_addr, 16'h0010);
      checkOutput("fetch stall_if", 16'(stall_if), 16'd1);
    end
    @(negedge clk);
    checkOutput("fetch if_ack", 16'(if_ack), 16'd1);
    checkOutput("fetch if_rdata", if_rdata, 16'hB123);
    checkOutput("fetch mem_re released", 16'(mem_re), 16'd0);
    checkOutput("fetch stall_if at ack", 16'(stall_if), 16'd0);
    @(posedge clk); #1;
    if_req = 1'b0;

    // Store then load
    issueData(1'b0, 1'b1, 16'h0040, 16'h5A5A);
    @(negedge clk);
    checkOutput("store c0 stall_mem", 16'(stall_mem), 16'd1);
    for (int c = 1; c <= LATENCY; c++) begin
      @(negedge clk);
      checkOutput("store mem_we", 16'(mem_we), 16'd1);
      checkOutput("store mem_re", 16'(mem_re), 16'd0);
      checkOutput("store mem_addr", mem_addr, 16'h0040);
      checkOutput("store mem_wdata", mem_wdata, 16'h5A5A);
    end
    @(negedge clk);
    checkOutput("store d_ack", 16'(d_ack), 16'd1);
    checkOutput("store d_rdata unchanged", d_rdata, 16'h0000);
    checkOutput("store mem_we released", 16'(mem_we), 16'd0);
    @(posedge clk); #1;
    d_wr = 1'b0;
    applyStimulus(1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0, lat);
    checkOutput("load ack cycle", 16'(lat), 16'(LATENCY + 1));
    checkOutput("load d_rdata", d_rdata, 16'h5A5A);

    // Simultaneous fetch and load: data first, fetch right after
    doReset();
    fork
      applyStimulus(1'b1, 1'b0, 16'h0046, 16'h0000, 1'b0, dLat);
      fetchRequest(16'h0101, fLat);
    join
    checkOutput("contention d_ack cycle", 16'(dLat), 16'd3);
    checkOutput("contention if_ack cycle", 16'(fLat), 16'd7);

    // hlt blocks fetch grants; fetch completes once hlt drops
    doReset();
    hlt = 1'b1; if_req = 1'b1; if_addr = 16'h0103; ifExpQ.push_back(refMem[9'h103]);
    reCnt = 0; ackCnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (mem_re) reCnt++;
      if (if_ack) ackCnt++;
    end
    checkOutput("mem_re cycles under hlt", 16'(reCnt), 16'd0);
    checkOutput("if_ack count under hlt", 16'(ackCnt), 16'd0);
    @(posedge clk); #1;
    hlt = 1'b0;
    waitFetchAck(lat);
    checkOutput("fetch ack cycle after hlt drop", 16'(lat), 16'(LATENCY + 1));

    // Reset during the last BUSY cycle of a load abandons it
    doReset();
    applyStimulus(1'b1, 1'b0, 16'h0041, 16'h0000, 1'b0, lat);
    issueData(1'b1, 1'b0, 16'h0042, 16'h0000);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; d_rd = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    dExpQ.delete(); ackLog.delete(); lastLoad = '0;
    @(negedge clk);
    checkOutput("mid-reset mem_re", 16'(mem_re), 16'd0);
    checkOutput("mid-reset mem_addr", mem_addr, 16'h0000);
    checkOutput("mid-reset d_ack", 16'(d_ack), 16'd0);
    checkOutput("mid-reset d_rdata", d_rdata, 16'h0000);
    repeat (4) @(negedge clk);
    checkOutput("acks after mid-reset", 16'(ackLog.size()), 16'd0);
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b0, 16'h0042, 16'h0000, 1'b0, lat);
    checkOutput("re-request ack cycle", 16'(lat), 16'(LATENCY + 1));

    // Read and write together: executed as a write, err sticky until reset
    doReset();
    applyStimulus(1'b1, 1'b1, 16'h0044, 16'h1234, 1'b0, lat);
    checkOutput("err after rd&wr grant", 16'(err), 16'd1);
    applyStimulus(1'b1, 1'b0, 16'h0044, 16'h0000, 1'b0, lat);
    checkOutput("rd&wr stored data", d_rdata, 16'h1234);
    checkOutput("err sticky", 16'(err), 16'd1);
    doReset();
    @(negedge clk);
    checkOutput("err cleared by rst", 16'(err), 16'd0);

    // Back-to-back data with fetch waiting
    doReset();
    fork
      begin
        for (int k = 0; k < 6; k++)
          applyStimulus(1'b1, 1'b0, 16'(16'h0040 + k), 16'h0000, (k < 5), dLat);
      end
      fetchRequest(16'h0105, fLat);
    join
    pos = -1;
    for (int i = 0; i < ackLog.size(); i++)
      if (ackLog[i] == 1'b0 && pos < 0) pos = i;
`ifdef STARVE_GUARD_EN
    checkOutput("fetch position in ack order", 16'(pos), 16'(MAX_BURST));
`else
    checkOutput("fetch position in ack order", 16'(pos), 16'd6);
`endif
    checkOutput("acks in burst run", 16'(ackLog.size()), 16'd7);

    // Randomized mixed traffic
    doReset();
    fork
      begin
        for (int k = 0; k < 30; k++) begin
          repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
          fetchRequest(16'(16'h0100 + $urandom_range(0, 15)), fLat);
        end
      end
      begin
        for (int k = 0; k < 30; k++) begin
          repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
          if ($urandom_range(0, 1) == 1)
            applyStimulus(1'b0, 1'b1, 16'(16'h0040 + $urandom_range(0, 15)),
                          16'($urandom), 1'b0, dLat);
          else
            applyStimulus(1'b1, 1'b0, 16'(16'h0040 + $urandom_range(0, 15)),
                          16'h0000, 1'b0, dLat);
        end
      end
    join
    repeat (3) @(negedge clk);
    checkOutput("fetch expectations drained", 16'(ifExpQ.size()), 16'd0);
    checkOutput("data expectations drained", 16'(dExpQ.size()), 16'd0);

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
